// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a block of 32-bit words over the rib read channel and
// streams them out on an 8N1 UART TX line, little-endian byte order.
module uart_mem_dump #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    input  logic [15:0] word_cnt_i,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_gnt_i,
    input  logic [31:0] rd_data_i,
    output logic        uart_tx,
    output logic        busy_o,
    output logic        done_o
);

    localparam int DIV = CLK_FREQ / BAUD;
    // keep the counter at least one bit wide even for DIV == 1
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        TX_START,
        TX_DATA,
        TX_STOP,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic [31:0]   addr;
    logic [31:0]   shw;      // shifts right one bit per data bit, so the next byte lands in [7:0]
    logic [15:0]   cnt;
    logic          baud_tick;
    logic          in_tx;

    assign baud_tick = (baud_cnt == BAUD_LAST);
    assign in_tx     = (state == TX_START) || (state == TX_DATA) || (state == TX_STOP);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state decode and outputs
    always_comb begin
        state_nx  = state;
        rd_req_o  = 1'b0;
        rd_addr_o = addr;
        uart_tx   = 1'b1;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        unique case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nx = (word_cnt_i == 16'd0) ? DONE : RD;
            end
            RD: begin
                rd_req_o = 1'b1;
                if (rd_gnt_i) state_nx = TX_START;
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (baud_tick) state_nx = TX_DATA;
            end
            TX_DATA: begin
                uart_tx = shw[0];
                if (baud_tick && bit_cnt == 3'd7) state_nx = TX_STOP;
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (byte_idx != 2'd3)  state_nx = TX_START;
                    else if (cnt == 16'd1) state_nx = DONE;
                    else                   state_nx = RD;
                end
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // baud counter: restarts on every state change, wraps at DIV-1 inside a state
    always_ff @(posedge clk) begin
        if (rst)                           baud_cnt <= '0;
        else if (state_nx != state || !in_tx || baud_tick) baud_cnt <= '0;
        else                               baud_cnt <= baud_cnt + 1'b1;
    end

    // datapath: address/count bookkeeping, shift word, bit and byte indices
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            cnt      <= '0;
            shw      <= '0;
            byte_idx <= '0;
            bit_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        addr <= {base_addr_i[31:2], 2'b00};
                        cnt  <= word_cnt_i;
                    end
                end
                RD: begin
                    if (rd_gnt_i) begin
                        shw      <= rd_data_i;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                    end
                end
                TX_DATA: begin
                    if (baud_tick) begin
                        shw     <= {1'b0, shw[31:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_tick) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            cnt  <= cnt - 16'd1;
                            addr <= addr + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: bus responder with programmable stalls, UART
// decoder, and a word/byte/timing reference built from the dump rules.
module tb_uart_mem_dump;
    localparam int CLK_FREQ = 50;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] word_cnt_i = '0;
    logic        rd_gnt_i = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic        rd_req_o, uart_tx, busy_o, done_o;
    logic [31:0] rd_addr_o;

    uart_mem_dump #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .word_cnt_i(word_cnt_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
        .rd_gnt_i(rd_gnt_i), .rd_data_i(rd_data_i), .uart_tx(uart_tx),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_addr_q[$];
    int          rd_len_q[$];
    int          stall_q[$];
    logic [7:0]  rx_q[$];
    int          start_stamp_q[$];
    int done_cnt = 0, frame_req_viol = 0, addr_move_viol = 0;
    int req_cycles = 0, tx_low_cycles = 0, frame_err = 0;
    int stall_word = -1, stall_len = 0, word_idx = 0;
    bit rand_stall = 1'b0;
    int n_cmp = 0, n_err = 0;

    // bus responder: grants after a chosen stall, returns memory contents on grant only
    initial begin : responder
        int left, reqc;
        logic [31:0] held;
        left = 0; reqc = 0; held = '0;
        forever begin
            @(negedge clk);
            rd_gnt_i  = 1'b0;
            rd_data_i = $urandom;
            if (rst || !rd_req_o) begin
                reqc = 0;
            end else begin
                if (reqc == 0) begin
                    held = rd_addr_o;
                    if (word_idx == stall_word) left = stall_len;
                    else if (rand_stall)        left = $urandom_range(0, 3);
                    else                        left = 0;
                    stall_q.push_back(left);
                end else if (rd_addr_o !== held) begin
                    addr_move_viol++;
                end
                reqc++;
                if (left > 0) begin
                    left--;
                end else begin
                    rd_gnt_i  = 1'b1;
                    rd_data_i = mem.exists(rd_addr_o) ? mem[rd_addr_o] : 32'hDEAD_BEEF;
                    rd_addr_q.push_back(rd_addr_o);
                    rd_len_q.push_back(reqc);
                    word_idx++;
                    reqc = 0;
                end
            end
        end
    end

    // UART decoder: samples mid-bit relative to the detected start edge
    int t = 0, j = 0;
    bit act = 1'b0;
    logic [7:0] sh = '0;
    always @(negedge clk) begin
        if (rst) begin
            act = 1'b0;
        end else begin
            if (done_o)         done_cnt++;
            if (rd_req_o)       req_cycles++;
            if (!uart_tx)       tx_low_cycles++;
            if (act && rd_req_o) frame_req_viol++;
            if (!act && !uart_tx) begin
                act = 1'b1; t = 0;
                start_stamp_q.push_back(cyc);
            end else if (act) begin
                t++;
            end
            if (act && t >= DIV / 2 && (t - DIV / 2) % DIV == 0) begin
                j = (t - DIV / 2) / DIV;
                if (j == 0) begin
                    if (uart_tx) frame_err++;
                end else if (j < 9) begin
                    sh = {uart_tx, sh[7:1]};
                end else begin
                    if (!uart_tx) frame_err++;
                    rx_q.push_back(sh);
                    act = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_addr_q.delete(); rd_len_q.delete(); stall_q.delete();
        rx_q.delete(); start_stamp_q.delete();
        done_cnt = 0; frame_req_viol = 0; addr_move_viol = 0;
        req_cycles = 0; tx_low_cycles = 0; frame_err = 0; word_idx = 0;
    endtask

    logic [31:0] cur_base;
    int          cur_cnt, acc_cyc;

    task automatic begin_dump(input logic [31:0] base, input int cnt,
                              input int sw, input int sl, input bit rnd);
        logic [31:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            if (!mem.exists(a)) mem[a] = $urandom;
        end
        @(negedge clk);
        clear_logs();
        stall_word = sw; stall_len = sl; rand_stall = rnd;
        cur_base = base; cur_cnt = cnt;
        base_addr_i = base; word_cnt_i = 16'(cnt); start_i = 1'b1;
        acc_cyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
        base_addr_i = $urandom; word_cnt_i = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget, output int dcyc);
        bit got;
        got = 1'b0; dcyc = -1;
        for (int i = 0; i < budget && !got; i++) begin
            if (done_o) begin got = 1'b1; dcyc = cyc; end
            else @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd1);
            @(negedge clk);
            chk({tag, "_busy_after"}, 64'(busy_o), 64'd0);
            chk({tag, "_done_1cyc"}, 64'(done_o), 64'd0);
        end
    endtask

    task automatic end_dump(input string tag);
        int dcyc, exp_done;
        logic [31:0] a, w, sft;
        wait_done(tag, cur_cnt * (40 * DIV + 20) + 100, dcyc);
        chk({tag, "_nreads"}, 64'(rd_addr_q.size()), 64'(cur_cnt));
        chk({tag, "_nbytes"}, 64'(rx_q.size()), 64'(4 * cur_cnt));
        for (int i = 0; i < cur_cnt && i < rd_addr_q.size(); i++) begin
            a = {cur_base[31:2], 2'b00} + 32'(4 * i);
            chk({tag, "_addr"}, 64'(rd_addr_q[i]), 64'(a));
            chk({tag, "_reqlen"}, 64'(rd_len_q[i]), 64'(stall_q[i] + 1));
        end
        for (int i = 0; i < 4 * cur_cnt && i < rx_q.size(); i++) begin
            a   = {cur_base[31:2], 2'b00} + 32'(4 * (i / 4));
            w   = mem[a];
            sft = w >> (8 * (i % 4));
            chk({tag, "_byte"}, 64'(rx_q[i]), 64'(sft[7:0]));
        end
        if (start_stamp_q.size() == 4 * cur_cnt && stall_q.size() == cur_cnt) begin
            chk({tag, "_first_start"}, 64'(start_stamp_q[0]), 64'(acc_cyc + 2 + stall_q[0]));
            for (int i = 0; i < 4 * cur_cnt; i++)
                if (i % 4 != 3)
                    chk({tag, "_byte_time"}, 64'(start_stamp_q[i + 1] - start_stamp_q[i]), 64'(10 * DIV));
            exp_done = acc_cyc + 1;
            for (int i = 0; i < cur_cnt; i++) exp_done += 40 * DIV + 1 + stall_q[i];
            chk({tag, "_done_cycle"}, 64'(dcyc), 64'(exp_done));
        end else begin
            chk({tag, "_nframes"}, 64'(start_stamp_q.size()), 64'(4 * cur_cnt));
        end
        chk({tag, "_req_in_frame"}, 64'(frame_req_viol), 64'd0);
        chk({tag, "_addr_moved"}, 64'(addr_move_viol), 64'd0);
        chk({tag, "_framing"}, 64'(frame_err), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin : main
        int dcyc, saved;
        bit seen;
        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(rd_req_o), 64'd0);
        chk("rst_addr", 64'(rd_addr_o), 64'd0);
        chk("rst_tx", 64'(uart_tx), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);

        // single known word, immediate grant
        mem[32'h1000] = 32'hA5C3_0F81;
        begin_dump(32'h1000, 1, -1, 0, 1'b0);
        chk("t1_busy_n1", 64'(busy_o), 64'd1);
        chk("t1_req_n1", 64'(rd_req_o), 64'd1);
        end_dump("t1");
        if (rx_q.size() == 4) begin
            chk("t1_b0", 64'(rx_q[0]), 64'h81);
            chk("t1_b1", 64'(rx_q[1]), 64'h0F);
            chk("t1_b2", 64'(rx_q[2]), 64'hC3);
            chk("t1_b3", 64'(rx_q[3]), 64'hA5);
        end

        // unaligned base, 3 words, second word stalled 7 cycles, stray start mid-dump
        begin_dump(32'h2002, 3, 1, 7, 1'b0);
        repeat (100) @(negedge clk);
        base_addr_i = 32'h9000; word_cnt_i = 16'd5; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        end_dump("t2");
        if (rd_len_q.size() == 3) chk("t2_stall_len", 64'(rd_len_q[1]), 64'd8);

        // zero-length dump
        begin_dump(32'h3000, 0, -1, 0, 1'b0);
        wait_done("t3", 10, dcyc);
        chk("t3_done_cycle", 64'(dcyc), 64'(acc_cyc + 1));
        repeat (5) @(negedge clk);
        chk("t3_no_req", 64'(req_cycles), 64'd0);
        chk("t3_tx_high", 64'(tx_low_cycles), 64'd0);
        chk("t3_done_pulses", 64'(done_cnt), 64'd1);

        // address wrap
        begin_dump(32'hFFFF_FFFC, 2, -1, 0, 1'b1);
        end_dump("t4");

        // reset in the middle of a data bit
        begin_dump($urandom, 2, -1, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (!uart_tx) seen = 1'b1;
            else @(negedge clk);
        end
        chk("t5_frame_started", 64'(seen), 64'd1);
        repeat (3 * DIV + DIV / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_tx", 64'(uart_tx), 64'd1);
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_req", 64'(rd_req_o), 64'd0);
        saved = done_cnt;
        repeat (40) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt), 64'(saved));
        chk("t5_idle_tx", 64'(uart_tx), 64'd1);
        begin_dump($urandom, 2, -1, 0, 1'b1);
        end_dump("t5_after");

        // randomized dumps with random grant stalls
        for (int k = 0; k < 4; k++) begin
            begin_dump($urandom, $urandom_range(1, 3), -1, 0, 1'b1);
            end_dump("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
